// File: rtl/dequant12sx8u.sv
// Iterative shift-add dequantizer: 9-bit signed coefficient x 8-bit unsigned step -> 12-bit signed.
// Optional output clamp to [-2048, 2047] when DEQUANT_SAT_EN is defined; otherwise the result wraps.
module dequant12sx8u (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_q,
  input  logic [7:0]  in_step,
  input  logic [5:0]  in_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_coef,
  output logic [5:0]  out_idx,
  output logic [1:0]  dbg_state
);

  // Handshake rules: a beat moves on any rising edge where valid and ready are
  // both high; valid, once raised, holds with stable data until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t       state_q, state_d;
  logic         sign_q, sign_d;
  logic [8:0]   mag_q, mag_d;
  logic [7:0]   step_q, step_d;
  logic [5:0]   idx_q, idx_d;
  logic [16:0]  acc_q, acc_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [11:0]  out_coef_q, out_coef_d;
  logic [5:0]   out_idx_q, out_idx_d;

  logic [16:0]        addend;
  logic signed [17:0] prod;
  logic [11:0]        fix_coef;

  assign addend = {8'd0, mag_q} << cnt_q;
  assign prod   = sign_q ? $signed(18'd0 - {1'b0, acc_q}) : $signed({1'b0, acc_q});

`ifdef DEQUANT_SAT_EN
  always_comb begin
    fix_coef = prod[11:0];
    if (prod > 18'sd2047)
      fix_coef = 12'h7FF;
    else if (prod < -18'sd2048)
      fix_coef = 12'h800;
  end
`else
  assign fix_coef = prod[11:0];
`endif

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    step_d      = step_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_coef_d  = out_coef_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_q[8];
          // Two's-complement negate in 9 bits maps -256 onto unsigned 256.
          mag_d   = in_q[8] ? (9'd0 - in_q) : in_q;
          step_d  = in_step;
          idx_d   = in_idx;
          acc_d   = 17'd0;
          cnt_d   = 3'd0;
          state_d = ((in_q == 9'd0) || (in_step == 8'd0)) ? FIX : MULT;
        end
      end
      MULT: begin
        if (step_q[cnt_q])
          acc_d = acc_q + addend;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7)
          state_d = FIX;
      end
      FIX: begin
        out_coef_d  = fix_coef;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 9'd0;
      step_q      <= 8'd0;
      idx_q       <= 6'd0;
      acc_q       <= 17'd0;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_coef_q  <= 12'h000;
      out_idx_q   <= 6'h00;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // in_ready is gated by rst so it reads low throughout the reset cycle.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_idx   = out_idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dequant12sx8u.sv
// Bench for dequant12sx8u: directed vectors, an arithmetic reference model with an
// expected queue checked on every output handshake, and latency/backpressure/reset checks.
module tb_dequant12sx8u;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_q;
  logic [7:0]  in_step;
  logic [5:0]  in_idx;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coef;
  logic [5:0]  out_idx;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int hs_cnt   = 0;

  logic [17:0] exp_q[$];

  dequant12sx8u dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_q      (in_q),
    .in_step   (in_step),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: true integer product, then clamp or keep the low 12 bits.
  function automatic logic [11:0] model(input logic [8:0] q, input logic [7:0] s);
    int qi;
    int si;
    int p;
    qi = $signed(q);
    si = int'(s);
    p  = qi * si;
`ifdef DEQUANT_SAT_EN
    if (p > 2047) return 12'h7FF;
    if (p < -2048) return 12'h800;
`endif
    return p[11:0];
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] q, input logic [7:0] s, input logic [5:0] idx);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_q     = q;
    in_step  = s;
    in_idx   = idx;
    exp_q.push_back({idx, model(q, s)});
    step();
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    lat = cyc - acc_cyc;
  endtask

  // scoreboard: stability while held, and one expected pop per handshake
  logic        held_q = 1'b0;
  logic [11:0] held_coef;
  logic [5:0]  held_idx;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (held_q) begin
        chk("hold_coef", {20'd0, out_coef}, {20'd0, held_coef});
        chk("hold_idx", {26'd0, out_idx}, {26'd0, held_idx});
      end
      if (out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("sb_coef", {20'd0, out_coef}, {20'd0, e[11:0]});
          chk("sb_idx", {26'd0, out_idx}, {26'd0, e[17:12]});
        end
      end
      held_q    = !out_ready;
      held_coef = out_coef;
      held_idx  = out_idx;
    end else begin
      held_q = 1'b0;
    end
  end

  logic [8:0] tq[7]  = '{9'd1, 9'h1FF, 9'h100, 9'd255, 9'd17, 9'h180, 9'd3};
  logic [7:0] ts[7]  = '{8'd1, 8'd1, 8'd1, 8'd128, 8'd0, 8'd2, 8'd255};

  initial begin
    int lat;
    int hs0;
    logic bad;
    rst = 1'b1; in_valid = 1'b0; in_q = '0; in_step = '0; in_idx = '0; out_ready = 1'b1;
    step();
    step();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_coef", {20'd0, out_coef}, 32'h000);
    chk("reset_out_idx", {26'd0, out_idx}, 32'h00);
    rst = 1'b0;
    step();
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // 5 * 16
    send(9'd5, 8'd16, 6'd3);
    wait_valid(lat);
    chk("t1_latency", lat, 32'd9);
    chk("t1_coef", {20'd0, out_coef}, 32'h050);
    chk("t1_idx", {26'd0, out_idx}, 32'd3);
    step();
    chk("t1_in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    chk("t1_out_valid_after_hs", {31'd0, out_valid}, 32'd0);

    // -3 * 10, then a zero operand
    send(9'h1FD, 8'd10, 6'd4);
    wait_valid(lat);
    chk("t2_latency", lat, 32'd9);
    chk("t2_coef", {20'd0, out_coef}, 32'hFE2);
    step();
    send(9'd0, 8'd200, 6'd5);
    wait_valid(lat);
    chk("t3_zero_latency", lat, 32'd1);
    chk("t3_zero_coef", {20'd0, out_coef}, 32'h000);
    step();

    // boundary products
    send(9'd255, 8'd255, 6'd6);
    wait_valid(lat);
`ifdef DEQUANT_SAT_EN
    chk("t4_max_coef", {20'd0, out_coef}, 32'h7FF);
`else
    chk("t4_max_coef", {20'd0, out_coef}, 32'hE01);
`endif
    step();
    send(9'h100, 8'd255, 6'd7);
    wait_valid(lat);
`ifdef DEQUANT_SAT_EN
    chk("t5_min_coef", {20'd0, out_coef}, 32'h800);
`else
    chk("t5_min_coef", {20'd0, out_coef}, 32'h100);
`endif
    step();

    // table vectors, checked by the scoreboard
    for (int i = 0; i < 7; i++) begin
      send(tq[i], ts[i], 6'(10 + i));
      wait_valid(lat);
      chk("tbl_latency", lat, ((tq[i] == 9'd0) || (ts[i] == 8'd0)) ? 32'd1 : 32'd9);
      step();
    end

    // backpressure
    out_ready = 1'b0;
    send(9'd7, 8'd3, 6'd33);
    wait_valid(lat);
    chk("bp_coef", {20'd0, out_coef}, 32'h015);
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_q     = 9'(i + 40);
      in_step  = 8'd9;
      in_idx   = 6'(50 + i);
      step();
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("bp_single_handshake", hs_cnt - hs0, 32'd1);
    chk("bp_queue_empty", exp_q.size(), 32'd0);
    chk("bp_out_valid_clear", {31'd0, out_valid}, 32'd0);

    // reset mid-MULT discards the beat
    send(9'd100, 8'd50, 6'd12);
    repeat (4) step();
    rst = 1'b1;
    step();
    exp_q.delete();
    rst = 1'b0;
    chk("rst_out_coef", {20'd0, out_coef}, 32'h000);
    chk("rst_out_idx", {26'd0, out_idx}, 32'h00);
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) bad = 1'b1;
      step();
    end
    chk("rst_no_output", {31'd0, bad}, 32'd0);
    send(9'h1F0, 8'd9, 6'd21);
    wait_valid(lat);
    chk("rst_recover_latency", lat, 32'd9);
    chk("rst_recover_coef", {20'd0, out_coef}, 32'hF70);
    step();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=<20000", cyc);
    $fatal(1, "timeout");
  end

endmodule
